ind_bank: RTL and testbench
===========================

IND_BANK -- requirements
Module: ind_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of independent indicator channels.
REQ-002 The block SHALL have parameter HALF_CYC, default 800000, meaning the blink half-period in Clk cycles (>=1).
REQ-003 The block SHALL have parameter CW, default 24, meaning the phase-counter width, with 2^CW > HALF_CYC.
REQ-004 The block SHALL have the port Clk  in  1  system clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have the port reset  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have the port req  in  NCH  per-channel indicator request; for example, bit 0 is ambulance and bit 1 is farm car.
REQ-007 The block SHALL have the port mode  in  2*NCH  per-channel mode: 00 off, 01 steady, 10 blink, 11 blink-N-then-steady.
REQ-008 The block SHALL have the port nblink  in  4  blink-pair count for mode 11, shared by all channels.
REQ-009 The block SHALL have the port ind  out  NCH  registered indicator drive.
REQ-010 The block SHALL have the port active  out  NCH  registered flag, high while the channel FSM is not IDLE.

Function
REQ-011 Each channel SHALL run its own FSM with the states IDLE, ON, OFF and STEADY, plus a CW-bit phase counter and a 4-bit pair counter.
REQ-012 IDLE SHALL go to a new state when req is 1 and mode is not 00: 01 goes to STEADY, 10 goes to ON, and 11 goes to ON if nblink is not 0, otherwise to STEADY; mode and nblink SHALL be captured on this transition.
REQ-013 Captured mode and nblink SHALL be held while the channel is active; changes on the inputs mid-operation SHALL be ignored until the channel next leaves IDLE.
REQ-014 The ON and OFF states SHALL each last exactly HALF_CYC cycles, so the blink period is 2*HALF_CYC; the phase counter SHALL clear on every state entry.
REQ-015 Leaving OFF SHALL increment the pair counter; in mode 11, when the pair count equals the captured nblink the channel SHALL go to STEADY, otherwise it SHALL go to ON.
REQ-016 ind SHALL be 1 in ON and STEADY and 0 in IDLE and OFF; ind and active SHALL rise on the first Clk edge after req is sampled high (1-cycle latency).
REQ-017 req at 0 in any non-IDLE state SHALL force IDLE, with ind = 0 and the counters cleared, on the next edge.
REQ-018 Re-asserting req SHALL restart the sequence from the ON phase with the pair count at zero; no phase is carried over.
REQ-019 The counters SHALL saturate and never wrap while held in STEADY.

Reset
REQ-020 When reset is 1 on an edge, every channel SHALL go to IDLE and ind, active, the counters and the captured mode SHALL all be 0, overriding all other inputs.
REQ-021 After reset releases, a held req SHALL be treated as a new request per REQ-012.

Configuration
REQ-022 When IND_LATCH_EN is defined, the block SHALL add the input port ack  in  NCH, and a channel SHALL stay active after req drops until ack is sampled 1.
REQ-023 With IND_LATCH_EN, req at 1 together with ack at 1 SHALL keep the channel active, and ack at 1 while req is 0 SHALL force IDLE on the next edge.
REQ-024 Without IND_LATCH_EN, the ack port SHALL be absent and REQ-017 SHALL apply unchanged.

Structure
REQ-025 The shared package ind_pkg SHALL hold the state enum (IDLE, ON, OFF, STEADY), the mode encoding constants and the nblink width.
REQ-026 The per-channel FSM and counters SHALL be a sub-module ind_chan, instantiated NCH times by a generate loop in ind_bank.

Verification
REQ-027 The bench SHALL cover: HALF_CYC=4, ch0 mode 01, req rising at cycle 10 -> ind[0] = 1 at cycle 11; req falling at cycle 20 -> ind[0] = 0 at cycle 21.
REQ-028 The bench SHALL cover: mode 10, req held -> ind shows 4 cycles at 1, 4 at 0, repeating; req dropped in the 2nd ON cycle -> ind = 0 next cycle; re-request -> a fresh 4-cycle ON phase.
REQ-029 The bench SHALL cover: mode 11, nblink=2 -> 2 on/off pairs (16 cycles) and then ind steady at 1; with nblink=0 -> steady from the first cycle.
REQ-030 The bench SHALL cover: reset pulsed mid-OFF with req held high -> ind and active at 0 for the reset cycle, then the sequence restarts with ON one cycle after release.
REQ-031 The bench SHALL cover: mode switched from 10 to 01 while active -> blinking continues; after req drops and re-asserts -> steady.
REQ-032 The bench SHALL cover, with IND_LATCH_EN: a 1-cycle req pulse on ch1 in mode 10 -> blinking continues until ack[1]; ack and req high together -> the channel stays active.

Source files
------------

// File: rtl/ind_pkg.sv
// ----------------------------------------------------------------------------
// ind_pkg
// Shared definitions for the indicator bank.
//   - ind_state_e   : per-channel FSM state (IDLE, ON, OFF, STEADY)
//   - MODE_*        : 2-bit per-channel mode encoding
//   - NB_W          : width of the blink-pair count (nblink)
//   - sat_inc_nb()  : saturating increment for the pair counter
// ----------------------------------------------------------------------------
package ind_pkg;

   localparam int NB_W = 4;

   localparam logic [1:0] MODE_OFF     = 2'b00;
   localparam logic [1:0] MODE_STEADY  = 2'b01;
   localparam logic [1:0] MODE_BLINK   = 2'b10;
   localparam logic [1:0] MODE_BLINK_N = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ON     = 2'd1,
      OFF    = 2'd2,
      STEADY = 2'd3
   } ind_state_e;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [NB_W-1:0] sat_inc_nb(input logic [NB_W-1:0] v);
      if (v == {NB_W{1'b1}}) begin
         return v;
      end
      return v + NB_W'(1);
   endfunction

endpackage

// File: rtl/ind_if.sv
// ----------------------------------------------------------------------------
// ind_if
// Request/drive bundle between a controller and the indicator bank.
// Build option: IND_LATCH_EN adds the per-channel ack signal.
//   req    [NCH]    per-channel indicator request      (master -> slave)
//   mode   [2*NCH]  per-channel mode, 2 bits each       (master -> slave)
//   nblink [NB_W]   blink-pair count for mode 11        (master -> slave)
//   ack    [NCH]    release for latched channels        (master -> slave, IND_LATCH_EN only)
//   ind    [NCH]    registered indicator drive          (slave -> master)
//   active [NCH]    channel FSM not IDLE                (slave -> master)
// ----------------------------------------------------------------------------
interface ind_if
   import ind_pkg::*;
#(
   parameter int NCH = 4
);

   logic [NCH-1:0]   req;
   logic [2*NCH-1:0] mode;
   logic [NB_W-1:0]  nblink;
`ifdef IND_LATCH_EN
   logic [NCH-1:0]   ack;
`endif
   logic [NCH-1:0]   ind;
   logic [NCH-1:0]   active;

`ifdef IND_LATCH_EN
   modport master (output req, output mode, output nblink, output ack,
                   input ind, input active);
   modport slave  (input req, input mode, input nblink, input ack,
                   output ind, output active);
`else
   modport master (output req, output mode, output nblink,
                   input ind, input active);
   modport slave  (input req, input mode, input nblink,
                   output ind, output active);
`endif

endinterface

// File: rtl/ind_chan.sv
// ----------------------------------------------------------------------------
// ind_chan
// One indicator channel: FSM (IDLE/ON/OFF/STEADY), CW-bit phase counter and
// NB_W-bit pair counter. Mode and nblink are captured when leaving IDLE and
// held for the whole activation.
// Build option: IND_LATCH_EN -- channel keeps running after req drops and is
// released only by ack sampled high while req is low.
// Ports:
//   Clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   req     in   indicator request
//   mode    in   2-bit mode (00 off, 01 steady, 10 blink, 11 blink-N-then-steady)
//   nblink  in   blink-pair count for mode 11
//   ack     in   release (IND_LATCH_EN only)
//   ind     out  registered indicator drive
//   active  out  registered "not IDLE" flag
// ----------------------------------------------------------------------------
module ind_chan
   import ind_pkg::*;
#(
   parameter int HALF_CYC = 800000,
   parameter int CW       = 24
) (
   input  logic            Clk,
   input  logic            reset,
   input  logic            req,
   input  logic [1:0]      mode,
   input  logic [NB_W-1:0] nblink,
`ifdef IND_LATCH_EN
   input  logic            ack,
`endif
   output logic            ind,
   output logic            active
);

   localparam logic [CW-1:0] PHASE_LAST = CW'(HALF_CYC - 1);
   localparam logic [CW-1:0] PHASE_ONE  = CW'(1);

   ind_state_e      state_q, state_d;
   logic [CW-1:0]   phase_q, phase_d;
   logic [NB_W-1:0] pair_q,  pair_d;
   logic [1:0]      mode_q,  mode_d;
   logic [NB_W-1:0] nb_q,    nb_d;
   logic            ind_q,   ind_d;
   logic            active_q, active_d;

   logic            release_w;
   logic [NB_W-1:0] pair_inc;

`ifdef IND_LATCH_EN
   // Latched: dropping req alone does not stop the channel; ack does.
   assign release_w = !req && ack;
`else
   assign release_w = !req;
`endif

   assign pair_inc = sat_inc_nb(pair_q);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pair_d  = pair_q;
      mode_d  = mode_q;
      nb_d    = nb_q;

      unique case (state_q)
         IDLE: begin
            phase_d = '0;
            pair_d  = '0;
            if (req && (mode != MODE_OFF)) begin
               mode_d = mode;
               nb_d   = nblink;
               if ((mode == MODE_STEADY) ||
                   ((mode == MODE_BLINK_N) && (nblink == '0))) begin
                  state_d = STEADY;
               end else begin
                  state_d = ON;
               end
            end
         end

         ON: begin
            if (phase_q == PHASE_LAST) begin
               state_d = OFF;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end

         OFF: begin
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
               pair_d  = pair_inc;
               if ((mode_q == MODE_BLINK_N) && (pair_inc == nb_q)) begin
                  state_d = STEADY;
               end else begin
                  state_d = ON;
               end
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end

         STEADY: begin
            // Counters are frozen here so nothing can wrap during a long hold.
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Release overrides whatever the sequence wanted to do this cycle.
      if ((state_q != IDLE) && release_w) begin
         state_d = IDLE;
         phase_d = '0;
         pair_d  = '0;
         mode_d  = MODE_OFF;
         nb_d    = '0;
      end

      ind_d    = (state_d == ON) || (state_d == STEADY);
      active_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         pair_q   <= '0;
         mode_q   <= MODE_OFF;
         nb_q     <= '0;
         ind_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         pair_q   <= pair_d;
         mode_q   <= mode_d;
         nb_q     <= nb_d;
         ind_q    <= ind_d;
         active_q <= active_d;
      end
   end

   assign ind    = ind_q;
   assign active = active_q;

endmodule

// File: rtl/ind_bank.sv
// ----------------------------------------------------------------------------
// ind_bank
// Bank of NCH independent indicator channels (steady / blink / blink-N).
// Build option: IND_LATCH_EN -- channels latch on req and need ack to release.
// Parameters:
//   NCH       number of channels
//   HALF_CYC  blink half-period in Clk cycles (>= 1)
//   CW        phase-counter width, 2^CW > HALF_CYC
// Ports:
//   Clk    in     rising-edge clock
//   reset  in     synchronous, active-high reset
//   bus    slave  ind_if: req, mode, nblink, (ack) in; ind, active out
// ----------------------------------------------------------------------------
module ind_bank
   import ind_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int HALF_CYC = 800000,
   parameter int CW       = 24
) (
   input  logic  Clk,
   input  logic  reset,
   ind_if.slave  bus
);

   logic [NCH-1:0] ind_w;
   logic [NCH-1:0] active_w;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      ind_chan #(
         .HALF_CYC (HALF_CYC),
         .CW       (CW)
      ) u_chan (
         .Clk    (Clk),
         .reset  (reset),
         .req    (bus.req[i]),
         .mode   (bus.mode[2*i +: 2]),
         .nblink (bus.nblink),
`ifdef IND_LATCH_EN
         .ack    (bus.ack[i]),
`endif
         .ind    (ind_w[i]),
         .active (active_w[i])
      );
   end

   assign bus.ind    = ind_w;
   assign bus.active = active_w;

endmodule

// File: tb/tb_ind_bank.sv
// ----------------------------------------------------------------------------
// tb_ind_bank
// Directed bench for ind_bank with HALF_CYC = 4, NCH = 4.
// Build option: IND_LATCH_EN enables the latched-request scenario.
// ----------------------------------------------------------------------------
module tb_ind_bank;
   import ind_pkg::*;

   localparam int NCH = 4;
   localparam int HC  = 4;
   localparam int CW  = 8;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;

   ind_if #(.NCH(NCH)) bus ();

   ind_bank #(
      .NCH      (NCH),
      .HALF_CYC (HC),
      .CW       (CW)
   ) dut (
      .Clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle; inputs changed after this are seen at the next edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
      end
   endtask

   task automatic idle_all();
      bus.req  = '0;
      bus.mode = '0;
      bus.nblink = '0;
      step();
      step();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      bus.req  = '1;
      bus.mode = {4{MODE_STEADY}};
      step();
      tests++;
      if (bus.ind !== 4'b0000 || bus.active !== 4'b0000) begin
         fails++;
         $display("FAIL reset_hold got ind=%b act=%b exp 0000/0000", bus.ind, bus.active);
      end
      step();
      tests++;
      if (bus.ind !== 4'b0000 || bus.active !== 4'b0000) begin
         fails++;
         $display("FAIL reset_hold2 got ind=%b act=%b exp 0000/0000", bus.ind, bus.active);
      end
      reset = 1'b0;
      step();
      tests++;
      if (bus.ind !== 4'b1111 || bus.active !== 4'b1111) begin
         fails++;
         $display("FAIL reset_release got ind=%b act=%b exp 1111/1111", bus.ind, bus.active);
      end
      idle_all();
      tests++;
      if (bus.ind !== 4'b0000 || bus.active !== 4'b0000) begin
         fails++;
         $display("FAIL reset_drop got ind=%b act=%b exp 0000/0000", bus.ind, bus.active);
      end
   endtask

   task automatic test_steady();
      bus.mode[1:0] = MODE_STEADY;
      while (cyc < 10) step();
      bus.req[0] = 1'b1;
      step();
      chk("steady_rise_ind", bus.ind[0], 1'b1);
      chk("steady_rise_act", bus.active[0], 1'b1);
      chk("steady_other_ch", bus.ind[1], 1'b0);
      while (cyc < 20) begin
         step();
         chk("steady_hold", bus.ind[0], 1'b1);
      end
      bus.req[0] = 1'b0;
      step();
      chk("steady_fall_ind", bus.ind[0], 1'b0);
      chk("steady_fall_act", bus.active[0], 1'b0);
      idle_all();
   endtask

   task automatic test_blink();
      bus.mode[1:0] = MODE_BLINK;
      bus.req[0] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         chk("blink_pattern", bus.ind[0], ((k / 4) % 2) == 0);
         chk("blink_active", bus.active[0], 1'b1);
      end
      step();
      step();
      chk("blink_2nd_on", bus.ind[0], 1'b1);
      bus.req[0] = 1'b0;
      step();
      chk("blink_drop_ind", bus.ind[0], 1'b0);
      chk("blink_drop_act", bus.active[0], 1'b0);
      bus.req[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("blink_rereq", bus.ind[0], k < 4);
      end
      idle_all();
   endtask

   task automatic test_blink_n();
      bus.mode[1:0] = MODE_BLINK_N;
      bus.nblink = 4'd2;
      bus.req[0] = 1'b1;
      for (int k = 0; k < 24; k++) begin
         step();
         chk("blinkn_pattern", bus.ind[0], (k >= 16) || (((k / 4) % 2) == 0));
         chk("blinkn_active", bus.active[0], 1'b1);
      end
      idle_all();
      bus.mode[1:0] = MODE_BLINK_N;
      bus.nblink = 4'd0;
      bus.req[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("blinkn0_steady", bus.ind[0], 1'b1);
      end
      idle_all();
   endtask

   task automatic test_reset_mid();
      bus.mode[1:0] = MODE_BLINK;
      bus.req[0] = 1'b1;
      for (int k = 0; k < 6; k++) step();
      chk("rstmid_in_off", bus.ind[0], 1'b0);
      reset = 1'b1;
      step();
      chk("rstmid_ind", bus.ind[0], 1'b0);
      chk("rstmid_act", bus.active[0], 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rstmid_restart", bus.ind[0], k < 4);
         chk("rstmid_restart_act", bus.active[0], 1'b1);
      end
      idle_all();
   endtask

   task automatic test_mode_switch();
      bus.mode[1:0] = MODE_BLINK;
      bus.req[0] = 1'b1;
      step();
      chk("modesw_first", bus.ind[0], 1'b1);
      bus.mode[1:0] = MODE_STEADY;
      for (int k = 1; k < 10; k++) begin
         step();
         chk("modesw_still_blink", bus.ind[0], ((k / 4) % 2) == 0);
      end
      bus.req[0] = 1'b0;
      step();
      chk("modesw_drop", bus.ind[0], 1'b0);
      bus.req[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("modesw_steady", bus.ind[0], 1'b1);
      end
      idle_all();
   endtask

   task automatic test_channels();
      bus.mode = {MODE_OFF, MODE_STEADY, MODE_BLINK, MODE_OFF};
      bus.req  = 4'b1110;
      step();
      tests++;
      if (bus.ind !== 4'b0110 || bus.active !== 4'b0110) begin
         fails++;
         $display("FAIL chan_indep got ind=%b act=%b exp 0110/0110", bus.ind, bus.active);
      end
      for (int k = 1; k < 6; k++) step();
      tests++;
      if (bus.ind !== 4'b0100 || bus.active !== 4'b0110) begin
         fails++;
         $display("FAIL chan_indep_off got ind=%b act=%b exp 0100/0110", bus.ind, bus.active);
      end
      idle_all();
   endtask

`ifdef IND_LATCH_EN
   task automatic test_latch();
      bus.mode[3:2] = MODE_BLINK;
      bus.req[1] = 1'b1;
      step();
      chk("latch_first", bus.ind[1], 1'b1);
      bus.req[1] = 1'b0;
      for (int k = 1; k < 12; k++) begin
         step();
         chk("latch_blink", bus.ind[1], ((k / 4) % 2) == 0);
         chk("latch_active", bus.active[1], 1'b1);
      end
      bus.req[1] = 1'b1;
      bus.ack[1] = 1'b1;
      step();
      chk("latch_req_ack_act", bus.active[1], 1'b1);
      bus.req[1] = 1'b0;
      step();
      chk("latch_ack_ind", bus.ind[1], 1'b0);
      chk("latch_ack_act", bus.active[1], 1'b0);
      bus.ack[1] = 1'b0;
      idle_all();
   endtask
`endif

   initial begin
      tests      = 0;
      fails      = 0;
      cyc        = 0;
      reset      = 1'b1;
      bus.req    = '0;
      bus.mode   = '0;
      bus.nblink = '0;
`ifdef IND_LATCH_EN
      bus.ack    = '0;
`endif
      test_reset();
      cyc = 0;
      test_steady();
      test_blink();
      test_blink_n();
      test_reset_mid();
      test_mode_switch();
      test_channels();
`ifdef IND_LATCH_EN
      test_latch();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
